// File: rtl/core_pkg.sv
// Shared core definitions: default register-file geometry and the register address type.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int AW_DEF = addr_w(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-after-write scoreboard: one busy bit per register, set by issue reservations,
// cleared by writeback, with per-read-port busy flags for stall decisions.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic              rsv_ok,
  output logic [NRD-1:0]    rd_busy,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic            rsv_zero;
  logic [AW-1:0]   ra;

  always_comb begin
    clr_vec = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) clr_vec[wr_addr[j*AW +: AW]] = 1'b1;
    end
  end

  // A busy register being released this cycle may be re-reserved only when its data is forwarded.
  always_comb begin
    rsv_zero = (ZERO_REG != 0) && (rsv_addr == AW'(ZERO_ADDR));
    rsv_ok   = rsv_en && (rsv_zero || !busy[rsv_addr] ||
                          ((BYPASS != 0) && clr_vec[rsv_addr]));
    set_vec  = '0;
    if (rsv_ok && !rsv_zero) set_vec[rsv_addr] = 1'b1;
  end

  // Set after clear: a new producer overrides the retiring one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_vec) | set_vec;
  end

  always_comb begin
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if ((ZERO_REG != 0) && (ra == AW'(ZERO_ADDR)))
        rd_busy[i] = 1'b0;
      else if ((BYPASS != 0) && clr_vec[ra])
        rd_busy[i] = 1'b0;
      else
        rd_busy[i] = busy[ra];
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-after-write scoreboard and optional
// same-cycle write-to-read bypass.
module regfile_mp_sb
  import core_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] mem [NREG];
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;

  // Ports are applied in ascending order so the highest-index writer lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] &&
            !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == AW'(ZERO_ADDR))))
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      rv = mem[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) rv = wr_data[j*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (ra == AW'(ZERO_ADDR))) rv = '0;
      rd_data[i*XLEN +: XLEN] = rv;
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .rd_busy  (rd_busy),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios plus a randomized phase against a
// behavioural model; expectations queue up when stimulus is driven and drain at the sample point.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ok;
  logic [NREG-1:0]     busy_vec;

  regfile_mp_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  localparam int S_RD0 = 0, S_RD1 = 1, S_BUSY = 2, S_VEC = 3, S_OK = 4;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_reg [NREG];
  logic [31:0] m_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int src);
    case (src)
      S_RD0:   return rd_data[31:0];
      S_RD1:   return rd_data[63:32];
      S_BUSY:  return {30'b0, rd_busy};
      S_VEC:   return busy_vec;
      default: return {31'b0, rsv_ok};
    endcase
  endfunction

  task automatic push(input string tag, input int src, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, observe(e.src), e.exp);
    end
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    wr_en[port]              = 1'b1;
    wr_addr[port*AW +: AW]   = AW'(a);
    wr_data[port*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(input int a);
    rsv_en   = 1'b1;
    rsv_addr = AW'(a);
  endtask

  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  function automatic logic hit(input int a);
    return (wr_en[0] && int'(wr_addr[4:0]) == a) || (wr_en[1] && int'(wr_addr[9:5]) == a);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] v;
    v = m_reg[a];
    if (wr_en[0] && int'(wr_addr[4:0]) == a) v = wr_data[31:0];
    if (wr_en[1] && int'(wr_addr[9:5]) == a) v = wr_data[63:32];
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic logic m_rd_busy(input int a);
    return (a != 0) && m_busy[a] && !hit(a);
  endfunction

  function automatic logic m_rsv_ok();
    int r;
    r = int'(rsv_addr);
    return rsv_en && (r == 0 || !m_busy[r] || hit(r));
  endfunction

  task automatic m_step();
    logic ok;
    ok = m_rsv_ok();
    if (wr_en[0] && wr_addr[4:0] != 0) m_reg[wr_addr[4:0]] = wr_data[31:0];
    if (wr_en[1] && wr_addr[9:5] != 0) m_reg[wr_addr[9:5]] = wr_data[63:32];
    for (int a = 0; a < NREG; a++) if (hit(a)) m_busy[a] = 1'b0;
    if (ok && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
  endtask

  initial begin
    int a0, a1;
    rst = 1'b1;
    idle();
    rd(5, 7);
    #12;
    push("rst_vec", S_VEC, 32'h0);
    push("rst_rd0", S_RD0, 32'h0);
    push("rst_busy", S_BUSY, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean state after reset on every address
    for (int a = 0; a < NREG; a += 2) begin
      rd(a, a + 1);
      push("init_rd0", S_RD0, 32'h0);
      push("init_rd1", S_RD1, 32'h0);
      push("init_busy", S_BUSY, 32'h0);
      push("init_vec", S_VEC, 32'h0);
      cyc();
    end

    // Same-address dual write: port 1 wins, bypass visible same cycle
    wr(0, 5, 32'hDEADBEEF);
    wr(1, 5, 32'h12345678);
    rd(5, 6);
    push("waw_bypass", S_RD0, 32'h12345678);
    push("waw_bypass_rd1", S_RD1, 32'h0);
    cyc();
    idle();
    rd(5, 5);
    push("waw_stored0", S_RD0, 32'h12345678);
    push("waw_stored1", S_RD1, 32'h12345678);
    push("waw_nobusy", S_VEC, 32'h0);
    cyc();

    // Register 0 ignores writes and reservations
    wr(0, 0, 32'hFFFFFFFF);
    rsv(0);
    rd(0, 5);
    push("zero_bypass", S_RD0, 32'h0);
    push("zero_rsv_ok", S_OK, 32'h1);
    cyc();
    idle();
    rd(0, 5);
    push("zero_stored", S_RD0, 32'h0);
    push("zero_vec", S_VEC, 32'h0);
    cyc();

    // Reserve 7, then a refused second reservation
    rsv(7);
    push("rsv7_ok", S_OK, 32'h1);
    push("rsv7_vec_lat", S_VEC, 32'h0);
    cyc();
    idle();
    rsv(7);
    rd(0, 7);
    push("rsv7_vec", S_VEC, 32'h80);
    push("rsv7_again", S_OK, 32'h0);
    push("rsv7_rdbusy", S_BUSY, 32'h2);
    cyc();
    idle();
    push("rsv7_vec_hold", S_VEC, 32'h80);
    cyc();

    // Write and re-reserve 7 together: busy stays set, data updates
    wr(0, 7, 32'h0000A5A5);
    rsv(7);
    rd(7, 0);
    push("wrsv_ok", S_OK, 32'h1);
    push("wrsv_bypass", S_RD0, 32'h0000A5A5);
    push("wrsv_rdbusy", S_BUSY, 32'h0);
    cyc();
    idle();
    rd(7, 0);
    push("wrsv_vec", S_VEC, 32'h80);
    push("wrsv_data", S_RD0, 32'h0000A5A5);
    push("wrsv_rdbusy2", S_BUSY, 32'h1);
    cyc();
    wr(1, 7, 32'h00001111);
    cyc();
    idle();
    rd(7, 0);
    push("clr7_vec", S_VEC, 32'h0);
    push("clr7_data", S_RD0, 32'h00001111);
    cyc();

    // Async reset in the middle of a write/reserve cycle
    wr(0, 3, 32'h0000CAFE);
    rsv(12);
    cyc();
    idle();
    rd(3, 12);
    push("pre_rst_vec", S_VEC, 32'h1000);
    push("pre_rst_rd3", S_RD0, 32'h0000CAFE);
    push("pre_rst_busy", S_BUSY, 32'h2);
    cyc();
    wr(0, 3, 32'h0000BEEF);
    rsv(9);
    #2;
    rst = 1'b1;
    #1;
    push("arst_vec", S_VEC, 32'h0);
    drain();
    idle();
    rd(3, 12);
    #1;
    push("arst_rd3", S_RD0, 32'h0);
    push("arst_rd12", S_RD1, 32'h0);
    push("arst_busy", S_BUSY, 32'h0);
    drain();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd(3, 9);
    push("post_rst_rd3", S_RD0, 32'h0);
    push("post_rst_vec", S_VEC, 32'h0);
    cyc();

    // Randomized traffic against the model, addresses confined to force collisions
    for (int a = 0; a < NREG; a++) m_reg[a] = '0;
    m_busy = '0;
    for (int n = 0; n < 200; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) wr(0, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 1) == 1) wr(1, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 1) == 1) rsv($urandom_range(0, 7));
      a0 = $urandom_range(0, 7);
      a1 = $urandom_range(0, 7);
      rd(a0, a1);
      push("rnd_rd0", S_RD0, m_read(a0));
      push("rnd_rd1", S_RD1, m_read(a1));
      push("rnd_busy", S_BUSY, {30'b0, m_rd_busy(a1), m_rd_busy(a0)});
      push("rnd_ok", S_OK, {31'b0, m_rsv_ok()});
      push("rnd_vec", S_VEC, m_busy);
      @(negedge clk);
      drain();
      m_step();
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
